// File: rtl/serial_line_arbiter_if.sv
// -----------------------------------------------------------------------------
// serial_line_arbiter_if
//
// Bundle of the serial sources and the merged-line outputs of
// serial_line_arbiter.
//
// Handshake: there is no valid/ready pair on this bus. src_in/src_en are
// sampled on every rising clk_sys edge. line_out, owner, owner_valid and
// collision are registered, change only after that edge, and are meaningful
// every cycle; owner is only meaningful while owner_valid = 1.
//
// Signals:
//   src_in      [N-1:0]  serial level of each source
//   src_en      [N-1:0]  per-source enable
//   line_out             merged serial line
//   owner       [OW-1:0] index of the current owner
//   owner_valid          line is currently owned
//   collision            one-cycle pulse: a non-owner edge was rejected
//   dbg_state   [0:0]    arbiter FSM state (0 = IDLE, 1 = OWNED)
//
// Modports:
//   master : the side that drives the sources (core / testbench)
//   slave  : the arbiter
// -----------------------------------------------------------------------------
interface serial_line_arbiter_if #(
   parameter int N  = 3,
   parameter int OW = (N > 1) ? $clog2(N) : 1
);
   logic [N-1:0]  src_in;
   logic [N-1:0]  src_en;
   logic          line_out;
   logic [OW-1:0] owner;
   logic          owner_valid;
   logic          collision;
   logic [0:0]    dbg_state;

   modport master (
      output src_in,
      output src_en,
      input  line_out,
      input  owner,
      input  owner_valid,
      input  collision,
      input  dbg_state
   );

   modport slave (
      input  src_in,
      input  src_en,
      output line_out,
      output owner,
      output owner_valid,
      output collision,
      output dbg_state
   );
endinterface

// File: rtl/serial_line_arbiter.sv
// -----------------------------------------------------------------------------
// serial_line_arbiter
//
// Merges N serial transmitters (tape, MIDI, UART, ...) onto the single
// UART_TX line. The first enabled source that toggles takes the line and
// keeps it until it has been quiet at the idle level for TIMEOUT cycles or
// is disabled. Edges from other sources while the line is owned are dropped
// and reported on collision.
//
// Parameters:
//   N          number of sources (>= 1)
//   IDLE_LEVEL line level with no owner; reset value of the edge history
//   TIMEOUT    owner-quiet cycles before release (>= 1)
//
// Ports:
//   clk_sys    system clock
//   reset      synchronous, active-high reset
//   bus        serial_line_arbiter_if.slave (src_in, src_en in; line_out,
//              owner, owner_valid, collision, dbg_state out, all registered)
// -----------------------------------------------------------------------------
module serial_line_arbiter #(
   parameter int   N          = 3,
   parameter logic IDLE_LEVEL = 1'b1,
   parameter int   TIMEOUT    = 65535
) (
   input logic                  clk_sys,
   input logic                  reset,
   serial_line_arbiter_if.slave bus
);

   localparam int OW = (N > 1) ? $clog2(N) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_OWNED = 1'b1;

   // Index of the lowest set bit of v (0 when v is empty).
   function automatic logic [OW-1:0] lowest_idx(input logic [N-1:0] v);
      logic [OW-1:0] idx;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) idx = OW'(i);
      end
      return idx;
   endfunction

   // Bit idx of v; loop form keeps the select in range for any owner value.
   function automatic logic sel_bit(input logic [N-1:0] v, input logic [OW-1:0] idx);
      logic b;
      b = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (OW'(i) == idx) b = v[i];
      end
      return b;
   endfunction

   // True when more than one bit of v is set, i.e. the lowest-index winner
   // has at least one loser alongside it.
   function automatic logic has_loser(input logic [N-1:0] v);
      return |(v & (v - N'(1)));
   endfunction

   // Registers
   logic [0:0]    r_state;
   logic [N-1:0]  r_prev;
   logic [TW-1:0] r_timer;
   logic [OW-1:0] r_owner;
   logic          r_owner_valid;
   logic          r_line;
   logic          r_collision;

   // Combinational
   logic [N-1:0]  w_edge;
   logic [N-1:0]  w_other_edge;
   logic          w_own_edge;
   logic          w_own_level;
   logic          w_own_en;
   logic          w_release;
   logic [0:0]    w_nxt_state;
   logic [TW-1:0] w_nxt_timer;
   logic [OW-1:0] w_nxt_owner;
   logic          w_nxt_owner_valid;
   logic          w_nxt_line;
   logic          w_nxt_collision;

   // Edge detection. prev follows src_in regardless of enable so a source
   // that gets enabled does not see a stale history as an edge.
   always_comb begin
      w_edge      = (bus.src_in ^ r_prev) & bus.src_en;
      w_own_edge  = sel_bit(w_edge, r_owner);
      w_own_level = sel_bit(bus.src_in, r_owner);
      w_own_en    = sel_bit(bus.src_en, r_owner);
      w_other_edge = '0;
      for (int i = 0; i < N; i++) begin
         w_other_edge[i] = w_edge[i] & (r_owner != OW'(i));
      end
      // Timer release needs the owner quiet and parked at idle; a disabled
      // owner is dropped unconditionally.
      w_release = ((r_timer == '0) && !w_own_edge && (w_own_level == IDLE_LEVEL))
                  || !w_own_en;
   end

   // Next-state logic
   always_comb begin
      w_nxt_state       = r_state;
      w_nxt_timer       = r_timer;
      w_nxt_owner       = r_owner;
      w_nxt_owner_valid = r_owner_valid;
      w_nxt_line        = r_line;
      w_nxt_collision   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (|w_edge) begin
               w_nxt_state       = ST_OWNED;
               w_nxt_owner       = lowest_idx(w_edge);
               w_nxt_owner_valid = 1'b1;
               w_nxt_line        = sel_bit(bus.src_in, lowest_idx(w_edge));
               w_nxt_timer       = TIMER_LOAD;
               w_nxt_collision   = has_loser(w_edge);
            end else begin
               w_nxt_owner_valid = 1'b0;
               w_nxt_line        = IDLE_LEVEL;
            end
         end

         ST_OWNED: begin
            if (w_release) begin
               if (|w_other_edge) begin
                  // Handover: the lowest edging non-owner takes the line in
                  // the same cycle, so owner_valid never drops.
                  w_nxt_state       = ST_OWNED;
                  w_nxt_owner       = lowest_idx(w_other_edge);
                  w_nxt_owner_valid = 1'b1;
                  w_nxt_line        = sel_bit(bus.src_in, lowest_idx(w_other_edge));
                  w_nxt_timer       = TIMER_LOAD;
                  w_nxt_collision   = has_loser(w_other_edge);
               end else begin
                  w_nxt_state       = ST_IDLE;
                  w_nxt_owner_valid = 1'b0;
                  w_nxt_line        = IDLE_LEVEL;
                  w_nxt_timer       = '0;
               end
            end else begin
               w_nxt_line      = w_own_level;
               w_nxt_collision = |w_other_edge;
               if (w_own_edge) begin
                  w_nxt_timer = TIMER_LOAD;
               end else if (r_timer != '0) begin
                  w_nxt_timer = r_timer - TW'(1);
               end
            end
         end

         default: begin
            w_nxt_state       = ST_IDLE;
            w_nxt_owner_valid = 1'b0;
            w_nxt_line        = IDLE_LEVEL;
            w_nxt_timer       = '0;
         end
      endcase
   end

   // State registers. During reset prev is forced to the idle level, so any
   // source toggle in a reset cycle is lost.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_prev        <= {N{IDLE_LEVEL}};
         r_timer       <= '0;
         r_owner       <= '0;
         r_owner_valid <= 1'b0;
         r_line        <= IDLE_LEVEL;
         r_collision   <= 1'b0;
      end else begin
         r_state       <= w_nxt_state;
         r_prev        <= bus.src_in;
         r_timer       <= w_nxt_timer;
         r_owner       <= w_nxt_owner;
         r_owner_valid <= w_nxt_owner_valid;
         r_line        <= w_nxt_line;
         r_collision   <= w_nxt_collision;
      end
   end

   assign bus.line_out    = r_line;
   assign bus.owner       = r_owner;
   assign bus.owner_valid = r_owner_valid;
   assign bus.collision   = r_collision;
   assign bus.dbg_state   = r_state;

endmodule
